// File: rtl/solitaire_pkg.sv
// Shared solitaire definitions: card word layout, pile geometry and deal FSM states.
// Used by the dealer and by the downstream move stage.
package solitaire_pkg;

    localparam int CARD_W        = 7;
    localparam int STOCK_SLOTS   = 24;
    localparam int TABLEAU_SLOTS = 19;
    localparam int TABLEAU_COUNT = 7;
    localparam int DECK_SIZE     = 52;
    localparam int TABLEAU_CARDS = 28;

    localparam int RANK_MSB = 6;
    localparam int RANK_LSB = 3;
    localparam int SUIT_MSB = 2;
    localparam int SUIT_LSB = 1;
    localparam int FLAG_BIT = 0;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        HEARTS   = 2'b00,
        CLUBS    = 2'b01,
        DIAMONDS = 2'b10,
        SPADES   = 2'b11
    } suit_e;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        DEAL,
        DONE
    } deal_state_e;

    typedef logic [CARD_W-1:0] card_t;

    function automatic card_t make_card(input logic [3:0] rank, input logic [1:0] suit,
                                        input logic face_up);
        return {rank, suit, face_up};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed is replaced by SEED_DEFAULT
// so the register can never lock up in the all-zero state.
module lfsr16
    import solitaire_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed_in,
    output logic [15:0] state
);

    logic [15:0] state_reg;
    logic [15:0] state_next;

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = (seed_in == 16'd0) ? SEED_DEFAULT : seed_in;
        end else if (enable) begin
            state_next = {1'b0, state_reg[15:1]} ^ (state_reg[0] ? LFSR_TAPS : 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= SEED_DEFAULT;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/deal_cards.sv
// Klondike dealer: Fisher-Yates shuffle of a 52-card deck driven by an LFSR with
// rejection sampling, then a 52-cycle deal into seven tableaux and the stock.
module deal_cards
    import solitaire_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [15:0]                       seed,
    output logic                              busy,
    output logic                              done,
    output logic [STOCK_SLOTS*CARD_W-1:0]     stock_pile,
    output logic [STOCK_SLOTS*CARD_W-1:0]     talon_pile,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau1,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau2,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau3,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau4,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau5,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau6,
    output logic [TABLEAU_SLOTS*CARD_W-1:0]   tableau7
);

    deal_state_e state_reg;
    deal_state_e state_next;

    card_t deck_reg    [DECK_SIZE];
    card_t deck_init   [DECK_SIZE];
    card_t stock_reg   [STOCK_SLOTS];
    card_t tableau_reg [TABLEAU_COUNT][TABLEAU_SLOTS];

    logic [TABLEAU_SLOTS*CARD_W-1:0] tableau_flat [TABLEAU_COUNT];

    logic [5:0]  i_reg;
    logic [5:0]  d_reg;
    logic [2:0]  row_reg;
    logic [2:0]  pile_reg;
    logic [4:0]  stock_slot;
    logic [15:0] lfsr_state;
    logic [5:0]  j_cand;
    logic        swap_ok;
    logic        lfsr_load;
    logic        lfsr_enable;
    logic        lfsr_unused;

    lfsr16 #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .enable  (lfsr_enable),
        .seed_in (seed),
        .state   (lfsr_state)
    );

    assign lfsr_load   = (state_reg == IDLE) && start;
    assign lfsr_enable = (state_reg == SHUFFLE);
    assign j_cand      = lfsr_state[5:0];
    assign lfsr_unused = ^lfsr_state[15:6];
    assign swap_ok     = (j_cand <= i_reg);
    assign stock_slot  = 5'(d_reg - 6'd28);

    // Fresh deck order: ranks 1..13 within each suit, suits in encoding order
    generate
        for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_deck_init
            assign deck_init[gi] = make_card(4'(gi % 13 + 1), 2'(gi / 13), 1'b0);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = INIT;
            end
            INIT: begin
                busy       = 1'b1;
                state_next = SHUFFLE;
            end
            SHUFFLE: begin
                busy = 1'b1;
                if (swap_ok && (i_reg == 6'd1)) state_next = DEAL;
            end
            DEAL: begin
                busy = 1'b1;
                if (d_reg == 6'(DECK_SIZE - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DECK_SIZE; k++) deck_reg[k] <= '0;
            for (int k = 0; k < STOCK_SLOTS; k++) stock_reg[k] <= '0;
            for (int t = 0; t < TABLEAU_COUNT; t++)
                for (int s = 0; s < TABLEAU_SLOTS; s++) tableau_reg[t][s] <= '0;
            i_reg    <= '0;
            d_reg    <= '0;
            row_reg  <= '0;
            pile_reg <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    for (int k = 0; k < DECK_SIZE; k++) deck_reg[k] <= deck_init[k];
                    for (int k = 0; k < STOCK_SLOTS; k++) stock_reg[k] <= '0;
                    for (int t = 0; t < TABLEAU_COUNT; t++)
                        for (int s = 0; s < TABLEAU_SLOTS; s++) tableau_reg[t][s] <= '0;
                    i_reg    <= 6'(DECK_SIZE - 1);
                    d_reg    <= '0;
                    row_reg  <= '0;
                    pile_reg <= '0;
                end
                SHUFFLE: begin
                    // j beyond i is rejected rather than folded, keeping the shuffle unbiased
                    if (swap_ok) begin
                        deck_reg[i_reg]  <= deck_reg[j_cand];
                        deck_reg[j_cand] <= deck_reg[i_reg];
                        i_reg            <= i_reg - 6'd1;
                    end
                    d_reg    <= '0;
                    row_reg  <= '0;
                    pile_reg <= '0;
                end
                DEAL: begin
                    if (d_reg < 6'(TABLEAU_CARDS)) begin
                        tableau_reg[pile_reg][{2'b00, row_reg}] <=
                            {deck_reg[d_reg][CARD_W-1:1], (row_reg == pile_reg)};
                        if (pile_reg == 3'd6) begin
                            row_reg  <= row_reg + 3'd1;
                            pile_reg <= row_reg + 3'd1;
                        end else begin
                            pile_reg <= pile_reg + 3'd1;
                        end
                    end else begin
                        stock_reg[stock_slot] <= {deck_reg[d_reg][CARD_W-1:1], 1'b1};
                    end
                    d_reg <= d_reg + 6'd1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < STOCK_SLOTS; gi++) begin : g_stock_out
            assign stock_pile[gi*CARD_W +: CARD_W] = stock_reg[gi];
        end
        for (genvar gi = 0; gi < TABLEAU_COUNT; gi++) begin : g_tab_out
            for (genvar gs = 0; gs < TABLEAU_SLOTS; gs++) begin : g_slot
                assign tableau_flat[gi][gs*CARD_W +: CARD_W] = tableau_reg[gi][gs];
            end
        end
    endgenerate

    assign talon_pile = '0;
    assign tableau1   = tableau_flat[0];
    assign tableau2   = tableau_flat[1];
    assign tableau3   = tableau_flat[2];
    assign tableau4   = tableau_flat[3];
    assign tableau5   = tableau_flat[4];
    assign tableau6   = tableau_flat[5];
    assign tableau7   = tableau_flat[6];

endmodule

// File: tb/tb_deal_cards.sv
// Bench for deal_cards: reference shuffle/deal model feeding a scoreboard queue,
// a table of seeds with expected deal relations, and reset / back-to-back sequences.
module tb_deal_cards;

    localparam int MAX_CYC = 3000;
    localparam int TAB_W   = 133;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  seed;
    logic         busy;
    logic         done;
    logic [167:0] stock_pile;
    logic [167:0] talon_pile;
    logic [132:0] tableau1, tableau2, tableau3, tableau4, tableau5, tableau6, tableau7;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    typedef struct {
        logic [167:0] stock;
        logic [930:0] tabs;
        int           latency;
    } exp_t;

    typedef struct {
        logic [15:0] seed;
        bit          poke;
        int          same_as;
        int          diff_from;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    logic [167:0] cap_stock [5];
    logic [930:0] cap_tabs  [5];

    deal_cards dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .stock_pile (stock_pile),
        .talon_pile (talon_pile),
        .tableau1   (tableau1),
        .tableau2   (tableau2),
        .tableau3   (tableau3),
        .tableau4   (tableau4),
        .tableau5   (tableau5),
        .tableau6   (tableau6),
        .tableau7   (tableau7)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    function automatic logic [930:0] dut_tabs();
        return {tableau7, tableau6, tableau5, tableau4, tableau3, tableau2, tableau1};
    endfunction

    task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_run(input logic [15:0] sd, output exp_t e);
        logic [15:0] l;
        logic [6:0]  deck [52];
        logic [6:0]  tmp;
        int i, j, cyc, d;
        l = (sd == 16'h0) ? 16'hACE1 : sd;
        for (int c = 0; c < 52; c++) deck[c] = {4'(c % 13 + 1), 2'(c / 13), 1'b0};
        i = 51;
        cyc = 0;
        while (i >= 1) begin
            j = int'(l[5:0]);
            cyc++;
            if (j <= i) begin
                tmp = deck[i]; deck[i] = deck[j]; deck[j] = tmp;
                i--;
            end
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        e.stock = '0;
        e.tabs  = '0;
        d = 0;
        for (int r = 0; r < 7; r++)
            for (int p = r; p < 7; p++) begin
                e.tabs[p*TAB_W + r*7 +: 7] = {deck[d][6:1], (r == p) ? 1'b1 : 1'b0};
                d++;
            end
        for (int s = 0; s < 24; s++) e.stock[s*7 +: 7] = {deck[28+s][6:1], 1'b1};
        e.latency = 1 + cyc + 52 + 1;
    endtask

    task automatic check_deal(input string tag);
        logic [930:0] t;
        logic [6:0]   c;
        bit           seen [64];
        int           bad, count;
        t = dut_tabs();
        bad = 0;
        count = 0;
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int k = 1; k <= 7; k++)
            for (int s = 0; s < 19; s++) begin
                c = t[(k-1)*TAB_W + s*7 +: 7];
                if (s < k) begin
                    if (c[0] != ((s == k - 1) ? 1'b1 : 1'b0)) bad++;
                    if (c[6:3] < 4'd1 || c[6:3] > 4'd13) bad++;
                    else if (seen[c[6:1]]) bad++;
                    else begin seen[c[6:1]] = 1'b1; count++; end
                end else if (c != 7'd0) bad++;
            end
        for (int s = 0; s < 24; s++) begin
            c = stock_pile[s*7 +: 7];
            if (!c[0]) bad++;
            if (c[6:3] < 4'd1 || c[6:3] > 4'd13) bad++;
            else if (seen[c[6:1]]) bad++;
            else begin seen[c[6:1]] = 1'b1; count++; end
        end
        check($sformatf("%s_shape_bad_slots", tag), bad, 0);
        check($sformatf("%s_distinct_cards", tag), count, 52);
    endtask

    task automatic run_game(input logic [15:0] sd, input bit poke, input string tag,
                            output logic [167:0] got_stock, output logic [930:0] got_tabs);
        exp_t e, ex;
        int cyc, dones0;
        model_run(sd, e);
        sb_q.push_back(e);
        dones0 = done_count;
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check($sformatf("%s_busy_after_start", tag), busy, 1);
        while (done !== 1'b1 && cyc < MAX_CYC) begin
            if (cyc == 2) begin
                check($sformatf("%s_stock_cleared", tag), stock_pile, 0);
                check($sformatf("%s_tab7_cleared", tag), tableau7, 0);
            end
            start = poke && (cyc == 10 || cyc == e.latency - 20);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        got_stock = stock_pile;
        got_tabs  = dut_tabs();
        ex = sb_q.pop_front();
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, MAX_CYC);
            return;
        end
        check($sformatf("%s_latency", tag), cyc, ex.latency);
        check($sformatf("%s_busy_at_done", tag), busy, 0);
        check($sformatf("%s_stock", tag), stock_pile, ex.stock);
        check($sformatf("%s_talon", tag), talon_pile, 0);
        for (int k = 0; k < 7; k++)
            check($sformatf("%s_tableau%0d", tag, k + 1), got_tabs[k*TAB_W +: TAB_W],
                  ex.tabs[k*TAB_W +: TAB_W]);
        check_deal(tag);
        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), done, 0);
        check($sformatf("%s_done_count", tag), done_count - dones0, 1);
        $display("game %s seed=%04h latency=%0d", tag, sd, cyc);
    endtask

    task automatic reset_mid_deal(input logic [15:0] sd);
        exp_t e;
        int cyc, target, dones0;
        model_run(sd, e);
        target = e.latency - 54 + 12;
        dones0 = done_count;
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
        check("rstdeal_partial_tableau1", tableau1, e.tabs[0 +: TAB_W]);
        check("rstdeal_busy_before", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rstdeal_busy", busy, 0);
        check("rstdeal_done", done, 0);
        check("rstdeal_stock", stock_pile, 0);
        check("rstdeal_talon", talon_pile, 0);
        check("rstdeal_tabs_or", |dut_tabs(), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rstdeal_no_done", done_count - dones0, 0);
        check("rstdeal_idle_busy", busy, 0);
        $display("reset at deal d=10 seed=%04h", sd);
    endtask

    initial begin
        logic [167:0] st;
        logic [930:0] tb;
        bit eq;
        rst   = 1'b0;
        start = 1'b0;
        seed  = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_stock", stock_pile, 0);
        check("reset_talon", talon_pile, 0);
        check("reset_tabs_or", |dut_tabs(), 0);
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{seed: 16'h1234, poke: 1'b0, same_as: -1, diff_from: -1};
        vecs[1] = '{seed: 16'h0000, poke: 1'b0, same_as: -1, diff_from: -1};
        vecs[2] = '{seed: 16'hACE1, poke: 1'b0, same_as: 1,  diff_from: -1};
        vecs[3] = '{seed: 16'hBEEF, poke: 1'b0, same_as: -1, diff_from: 0};
        vecs[4] = '{seed: 16'h1234, poke: 1'b1, same_as: 0,  diff_from: -1};

        for (int v = 0; v < 5; v++) begin
            run_game(vecs[v].seed, vecs[v].poke, $sformatf("vec%0d", v), st, tb);
            cap_stock[v] = st;
            cap_tabs[v]  = tb;
            if (vecs[v].same_as >= 0) begin
                eq = (cap_stock[v] === cap_stock[vecs[v].same_as]) &&
                     (cap_tabs[v] === cap_tabs[vecs[v].same_as]);
                check($sformatf("vec%0d_same_as_vec%0d", v, vecs[v].same_as), eq, 1);
            end
            if (vecs[v].diff_from >= 0) begin
                eq = (cap_stock[v] === cap_stock[vecs[v].diff_from]) &&
                     (cap_tabs[v] === cap_tabs[vecs[v].diff_from]);
                check($sformatf("vec%0d_differs_from_vec%0d", v, vecs[v].diff_from), eq, 0);
            end
        end

        reset_mid_deal(16'h5A5A);
        run_game(16'h5A5A, 1'b0, "after_rst", st, tb);

        run_game(16'h0F0F, 1'b0, "b2b_first", st, tb);
        cap_stock[0] = st;
        cap_tabs[0]  = tb;
        run_game(16'h7777, 1'b0, "b2b_second", st, tb);
        eq = (st === cap_stock[0]) && (tb === cap_tabs[0]);
        check("b2b_new_deal_differs", eq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deal_cards.md
DEAL_CARDS -- requirements
Module: deal_cards

Interface
REQ-001 Params: SEED_DEFAULT = 16'hACE1, substitute LFSR seed when seed input is zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to shuffle and deal a new game.
REQ-005 seed  input  16  LFSR seed, sampled on an accepted start.
REQ-006 busy  output  1  high from accepted start until done.
REQ-007 done  output  1  one-cycle pulse when all piles are valid; drives the move stage's ready.
REQ-008 stock_pile  output  168  24 card slots × 7 bits.
REQ-009 talon_pile  output  168  24 card slots × 7 bits; always zero from this block.
REQ-010 tableau1..tableau7  output  133 each  19 card slots × 7 bits.

Function
REQ-011 Card word: [6:3] rank 1..13 (ace=1), [2:1] suit (HEARTS 00, CLUBS 01, DIAMONDS 10, SPADES 11), [0] face-up/present flag; all-zero word = empty slot.
REQ-012 FSM states IDLE, INIT, SHUFFLE, DEAL, DONE; reset and completion return to IDLE.
REQ-013 IDLE: start=1 -> INIT, seed latched into LFSR, busy=1; start ignored in every other state.
REQ-014 INIT (1 cycle): internal 52-entry deck loaded with card c = {rank c%13+1, suit c/13, flag 0} for c = 0..51; all pile outputs cleared to zero; index i set to 51.
REQ-015 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle in SHUFFLE; seed 0 replaced by SEED_DEFAULT.
REQ-016 SHUFFLE: candidate j = LFSR[5:0]; if j <= i, swap deck[i] and deck[j] and decrement i; otherwise no swap (rejection), i unchanged.
REQ-017 SHUFFLE exits to DEAL in the cycle after the swap with i=1 completes; deal counter d set to 0.
REQ-018 DEAL: exactly one card per cycle, d = 0..51, 52 cycles total.
REQ-019 Cards d = 0..27 go to tableaux in rows: row r = 0..6, pile p = r..6 in order, placed in tableau(p+1) slot r; flag = 1 only when r == p, else 0.
REQ-020 Resulting shape: tableau k holds k cards in slots 0..k-1, only slot k-1 face-up; slots k..18 zero.
REQ-021 Cards d = 28..51 go to stock_pile slot d-28 with flag forced to 1.
REQ-022 DONE (1 cycle): done=1, busy=0, next state IDLE.
REQ-023 Pile outputs hold their dealt values in IDLE until the next accepted start's INIT cycle.
REQ-024 Latency: start to done = 1 (INIT) + 51 + rejections (SHUFFLE) + 52 (DEAL) + 1 cycles.
REQ-025 Deck indices 6 bits, rank/suit derivation via counters (no divide); d increments modulo none — DEAL exits at d = 51.

Reset
REQ-026 rst=0 at a clock edge: state IDLE, busy=0, done=0, all pile outputs zero, deck/counters zero, LFSR = SEED_DEFAULT.
REQ-027 Reset mid-INIT/SHUFFLE/DEAL aborts with no partial piles visible afterwards and no done pulse.

Structure
REQ-028 Shared package solitaire_pkg holds suit constants, CARD_W=7, STOCK_SLOTS=24, TABLEAU_SLOTS=19, DECK_SIZE=52, card-field slice positions; used by deal_cards and the move stage.
REQ-029 One sub-module lfsr16 (load, enable, seed in, state out); remainder in deal_cards.

Verification
REQ-030 seed=16'h1234, start -> one done pulse; 52 dealt cards form a permutation: each rank/suit pair exactly once; talon_pile == 0.
REQ-031 Any seed -> tableau k has k nonzero slots, only slot k-1 bit0=1; stock slots 0..23 all bit0=1; latency matches REQ-024 against LFSR model.
REQ-032 seed=0 vs seed=16'hACE1 -> identical deals; two different nonzero seeds -> different deals.
REQ-033 start pulsed during SHUFFLE and DEAL -> ignored, exactly one done, deal unchanged versus single-start run.
REQ-034 rst=0 asserted at DEAL d=10 -> next cycle all outputs zero, busy=0, no done; subsequent start produces complete valid deal.
REQ-035 Back-to-back games: start in cycle after done -> outputs cleared in INIT, new deal valid, old piles not retained.
